// File: rtl/i2s_iq_feeder_pkg.sv
// Shared types and defaults for the I2S I/Q feeder: FSM state encoding and the sample width.
package i2s_iq_feeder_pkg;

  localparam int DW_DEFAULT = 24;

  typedef enum logic [1:0] {
    FEED_IDLE  = 2'd0,
    FEED_PRIME = 2'd1,
    FEED_RUN   = 2'd2
  } feed_state_e;

endpackage

// File: rtl/i2s_iq_feeder_fifo.sv
// Sample FIFO for the feeder: synchronous write, head-of-queue peek that the consumer registers.
// A push into a full FIFO succeeds only when a pop happens in the same cycle.
module i2s_iq_feeder_fifo #(
  parameter  int WIDTH = 48,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             SAICLK,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [LW-1:0]    wr_cnt;
  logic [LW-1:0]    rd_cnt;
  logic             do_push;
  logic             do_pop;

  // Counters carry one extra bit so full and empty stay distinguishable.
  assign level   = wr_cnt - rd_cnt;
  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & ~flush & (~full | do_pop);
  assign rd_data = mem[rd_cnt[AW-1:0]];

  always_ff @(posedge SAICLK) begin
    if (!reset) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else if (flush) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (do_push) wr_cnt <= wr_cnt + LW'(1);
      if (do_pop)  rd_cnt <= rd_cnt + LW'(1);
    end
  end

  // NOTE: storage has no reset; the counters alone define which entries are valid.
  always_ff @(posedge SAICLK) begin
    if (reset && do_push) mem[wr_cnt[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/i2s_iq_feeder.sv
// Feeds one DDC I/Q pair per LRCLK frame to the I2S transmitter, buffering through a small FIFO
// and reporting sticky overflow/underflow.
module i2s_iq_feeder
  import i2s_iq_feeder_pkg::*;
#(
  parameter  int DW    = DW_DEFAULT,
  parameter  int DEPTH = 8,
  parameter  int PRIME = 4,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic          SAICLK,
  input  logic          reset,
  input  logic          en,
  input  logic [DW-1:0] ddc_real,
  input  logic [DW-1:0] ddc_imag,
  input  logic          ddc_tog,
  input  logic          LRCLK,
  input  logic          clr_flags,
  output logic [DW-1:0] rx_real,
  output logic [DW-1:0] rx_imag,
  output logic          frame_stb,
  output logic [LW-1:0] level,
  output logic          ovf,
  output logic          unf
);

  feed_state_e     state;
  logic [2:0]      tog_sync;
  logic [2:0]      lr_sync;
  logic            push_evt;
  logic            frame_evt;
  logic            flush;
  logic            push_req;
  logic            pop_req;
  logic            drop;
  logic            underrun;
  logic            full;
  logic            empty;
  logic [2*DW-1:0] head;

  // NOTE: every clocked block uses non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge SAICLK) begin
    if (!reset) begin
      tog_sync <= '0;
      lr_sync  <= '0;
    end else begin
      tog_sync <= {tog_sync[1:0], ddc_tog};
      lr_sync  <= {lr_sync[1:0], LRCLK};
    end
  end

  // Bit 1 is the synchronized level; bit 2 is its one-cycle-old copy for edge detection.
  assign push_evt  = tog_sync[1] ^ tog_sync[2];
  assign frame_evt = lr_sync[1] & ~lr_sync[2];

  assign flush    = ~en | (state == FEED_IDLE);
  assign push_req = push_evt & en;
  assign pop_req  = frame_evt & en &
                    (((state == FEED_PRIME) && (level >= LW'(PRIME))) ||
                     ((state == FEED_RUN) && !empty));
  assign drop     = push_req & full & ~pop_req & ~flush;
  assign underrun = frame_evt & en & (state == FEED_RUN) & empty;

  i2s_iq_feeder_fifo #(
    .WIDTH (2 * DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .SAICLK  (SAICLK),
    .reset   (reset),
    .push    (push_req),
    .pop     (pop_req),
    .flush   (flush),
    .wr_data ({ddc_real, ddc_imag}),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  always_ff @(posedge SAICLK) begin
    if (!reset) begin
      state     <= FEED_IDLE;
      rx_real   <= '0;
      rx_imag   <= '0;
      frame_stb <= 1'b0;
    end else begin
      frame_stb <= 1'b0;
      if (!en) begin
        state   <= FEED_IDLE;
        rx_real <= '0;
        rx_imag <= '0;
      end else begin
        case (state)
          FEED_IDLE: state <= FEED_PRIME;
          FEED_PRIME, FEED_RUN: begin
            if (frame_evt) begin
              frame_stb <= 1'b1;
              if (pop_req) begin
                rx_real <= head[2*DW-1:DW];
                rx_imag <= head[DW-1:0];
                state   <= FEED_RUN;
              end else begin
                // Still priming, or RUN found the FIFO empty: emit silence and re-prime.
                rx_real <= '0;
                rx_imag <= '0;
                state   <= FEED_PRIME;
              end
            end
          end
          default: state <= FEED_IDLE;
        endcase
      end
    end
  end

  // Setting a flag wins over clearing it in the same cycle.
  always_ff @(posedge SAICLK) begin
    if (!reset) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (drop)           ovf <= 1'b1;
      else if (clr_flags) ovf <= 1'b0;
      if (underrun)       unf <= 1'b1;
      else if (clr_flags) unf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_iq_feeder.sv
// Directed bench for i2s_iq_feeder: reset, priming, steady streaming, underflow, overflow
// and the push-with-pop-at-full / mid-frame disable corners.
module tb_i2s_iq_feeder;

  logic        SAICLK;
  logic        reset;
  logic        en;
  logic [23:0] ddc_real;
  logic [23:0] ddc_imag;
  logic        ddc_tog;
  logic        LRCLK;
  logic        clr_flags;
  logic [23:0] rx_real;
  logic [23:0] rx_imag;
  logic        frame_stb;
  logic [3:0]  level;
  logic        ovf;
  logic        unf;

  int tests = 0;
  int fails = 0;

  i2s_iq_feeder dut (
    .SAICLK    (SAICLK),
    .reset     (reset),
    .en        (en),
    .ddc_real  (ddc_real),
    .ddc_imag  (ddc_imag),
    .ddc_tog   (ddc_tog),
    .LRCLK     (LRCLK),
    .clr_flags (clr_flags),
    .rx_real   (rx_real),
    .rx_imag   (rx_imag),
    .frame_stb (frame_stb),
    .level     (level),
    .ovf       (ovf),
    .unf       (unf)
  );

  initial SAICLK = 1'b0;
  always #5 SAICLK = ~SAICLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge SAICLK);
    #1;
  endtask

  // A toggle lands in the FIFO on the third edge; the fourth tick leaves margin.
  task automatic push_sample(input logic [23:0] r);
    ddc_real = r;
    ddc_imag = ~r;
    ddc_tog  = ~ddc_tog;
    repeat (4) tick();
  endtask

  task automatic do_frame(output int stb_cnt, output logic [23:0] re, output logic [23:0] im);
    stb_cnt = 0;
    re = rx_real;
    im = rx_imag;
    LRCLK = 1'b1;
    repeat (5) begin
      tick();
      if (frame_stb) begin
        stb_cnt++;
        re = rx_real;
        im = rx_imag;
      end
    end
    LRCLK = 1'b0;
    repeat (3) tick();
  endtask

  task automatic frame_expect(input string tag, input logic [23:0] exp_re,
                              input logic [23:0] exp_im);
    int          cnt;
    logic [23:0] re;
    logic [23:0] im;
    do_frame(cnt, re, im);
    check({tag, "_stb"}, cnt, 1);
    check({tag, "_re"}, re, exp_re);
    check({tag, "_im"}, im, exp_im);
    check({tag, "_hold"}, rx_real, exp_re);
  endtask

  initial begin
    int          cnt;
    logic [23:0] re;
    logic [23:0] im;
    logic [23:0] next_push;
    logic [23:0] next_pop;

    reset     = 1'b0;
    en        = 1'b0;
    ddc_real  = '0;
    ddc_imag  = '0;
    ddc_tog   = 1'b0;
    LRCLK     = 1'b0;
    clr_flags = 1'b0;

    // Reset with toggles: nothing may be captured.
    for (int i = 0; i < 4; i++) begin
      if (i < 3) ddc_tog = ~ddc_tog;
      tick();
    end
    check("rst_rx_real", rx_real, 0);
    check("rst_rx_imag", rx_imag, 0);
    check("rst_level", level, 0);
    check("rst_ovf", ovf, 0);
    check("rst_unf", unf, 0);
    check("rst_stb", frame_stb, 0);

    reset = 1'b1;
    repeat (3) push_sample(24'h0000AA);
    check("idle_level", level, 0);
    do_frame(cnt, re, im);
    check("idle_stb", cnt, 0);
    check("idle_rx", rx_real, 0);

    // Prime: frames before the 4th push give zero output.
    en = 1'b1;
    repeat (2) tick();
    push_sample(24'h000001);
    push_sample(24'h000002);
    push_sample(24'h000003);
    frame_expect("prime_zero", 24'h000000, 24'h000000);
    check("prime_level3", level, 3);
    push_sample(24'h000004);
    check("prime_level4", level, 4);
    frame_expect("prime_first", 24'h000001, 24'hFFFFFE);
    check("prime_level_after", level, 3);
    frame_expect("prime_second", 24'h000002, 24'hFFFFFD);
    check("prime_level_2", level, 2);

    // Steady: one push per frame keeps occupancy at 3..4.
    next_push = 24'd5;
    next_pop  = 24'd3;
    push_sample(next_push);
    next_push++;
    for (int i = 0; i < 100; i++) begin
      push_sample(next_push);
      next_push++;
      check("steady_lvl_push", (level == 4'd3) || (level == 4'd4), 1);
      frame_expect("steady", next_pop, ~next_pop);
      next_pop++;
      check("steady_lvl_pop", (level == 4'd3) || (level == 4'd4), 1);
    end
    check("steady_ovf", ovf, 0);
    check("steady_unf", unf, 0);

    // Underflow: drain, then one frame with an empty FIFO.
    while (next_pop != next_push) begin
      frame_expect("drain", next_pop, ~next_pop);
      next_pop++;
    end
    check("drain_level", level, 0);
    check("drain_unf", unf, 0);
    frame_expect("unf_frame", 24'h000000, 24'h000000);
    check("unf_set", unf, 1);
    push_sample(24'd201);
    push_sample(24'd202);
    push_sample(24'd203);
    frame_expect("reprime", 24'h000000, 24'h000000);
    check("reprime_unf_sticky", unf, 1);
    push_sample(24'd204);
    frame_expect("resume", 24'd201, ~24'd201);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    check("unf_clear", unf, 0);

    // Overflow: flush, then 10 pushes with no frames.
    en = 1'b0;
    repeat (2) tick();
    check("flush_level", level, 0);
    check("flush_rx", rx_real, 0);
    en = 1'b1;
    repeat (2) tick();
    for (int i = 1; i <= 10; i++) push_sample(24'h000300 + 24'(i));
    check("ovf_level", level, 8);
    check("ovf_set", ovf, 1);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    check("ovf_clear", ovf, 0);
    frame_expect("ovf_first", 24'h000301, ~24'h000301);
    check("ovf_level7", level, 7);
    push_sample(24'h0003A0);
    check("refill_level", level, 8);

    // Push and frame event in the same cycle while full.
    ddc_real = 24'h0003B0;
    ddc_imag = ~24'h0003B0;
    ddc_tog  = ~ddc_tog;
    LRCLK    = 1'b1;
    repeat (3) tick();
    check("corner_stb", frame_stb, 1);
    check("corner_rx", rx_real, 24'h000302);
    check("corner_level", level, 8);
    check("corner_ovf", ovf, 0);
    LRCLK = 1'b0;
    repeat (4) tick();
    check("corner_level_hold", level, 8);

    // Samples 9 and 10 must be absent: 0x308 is followed by 0x3A0.
    for (int i = 3; i <= 8; i++) frame_expect("ovf_drain", 24'h000300 + 24'(i), ~(24'h000300 + 24'(i)));
    frame_expect("ovf_lost", 24'h0003A0, ~24'h0003A0);
    frame_expect("corner_push", 24'h0003B0, ~24'h0003B0);
    check("final_drain_level", level, 0);

    // Disable mid-frame.
    push_sample(24'h000400);
    push_sample(24'h000401);
    check("mid_level", level, 2);
    LRCLK = 1'b1;
    tick();
    en = 1'b0;
    repeat (2) tick();
    check("mid_rx_real", rx_real, 0);
    check("mid_rx_imag", rx_imag, 0);
    check("mid_level0", level, 0);
    LRCLK = 1'b0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
